// File: rtl/calc1_pkg.sv
// Shared command, response and state encodings for the calc1 request/response protocol.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP2  = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 arithmetic: unsigned 32-bit ADD/SUB/SHL/SHR with error reporting.
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [3:0]  cmd,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [1:0]  resp,
    output logic [31:0] data
);

    logic [32:0] sum_s;

    // Decode the command and produce the response code with its result data.
    always_comb begin
        sum_s = {1'b0, op1} + {1'b0, op2};
        resp  = RESP_ERR;
        data  = 32'd0;
        case (cmd)
            CMD_ADD: begin
                if (sum_s[32]) begin
                    resp = RESP_ERR;
                    data = 32'd0;
                end else begin
                    resp = RESP_OK;
                    data = sum_s[31:0];
                end
            end
            CMD_SUB: begin
                if (op2 > op1) begin
                    resp = RESP_ERR;
                    data = 32'd0;
                end else begin
                    resp = RESP_OK;
                    data = op1 - op2;
                end
            end
            // Only the low five bits of op2 select the shift distance.
            CMD_SHL: begin
                resp = RESP_OK;
                data = op1 << op2[4:0];
            end
            CMD_SHR: begin
                resp = RESP_OK;
                data = op1 >> op2[4:0];
            end
            default: begin
                resp = RESP_ERR;
                data = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// Calculator side of one calc1 port: two-cycle request capture, fixed-latency
// execution and a one-cycle registered response.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int unsigned LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_r;
    logic [3:0]  cmd_r;
    logic [31:0] op1_r;
    logic [31:0] op2_r;
    logic [3:0]  cnt_r;
    logic [1:0]  alu_resp_s;
    logic [31:0] alu_data_s;

    calc1_alu u_alu (
        .cmd  (cmd_r),
        .op1  (op1_r),
        .op2  (op2_r),
        .resp (alu_resp_s),
        .data (alu_data_s)
    );

    // Request/response state machine with registered outputs.
    always_ff @(posedge c_clk) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cmd_r    <= CMD_NOP;
            op1_r    <= 32'd0;
            op2_r    <= 32'd0;
            cnt_r    <= 4'd0;
            out_resp <= RESP_NONE;
            out_data <= 32'd0;
            busy     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_resp <= RESP_NONE;
                    out_data <= 32'd0;
                    if (req_cmd_in != CMD_NOP) begin
                        cmd_r   <= req_cmd_in;
                        op1_r   <= req_data_in;
                        state_r <= OP2;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                OP2: begin
                    op2_r   <= req_data_in;
                    cnt_r   <= CNT_LOAD;
                    state_r <= EXEC;
                    busy    <= 1'b1;
                end
                EXEC: begin
                    busy <= 1'b1;
                    if (cnt_r == 4'd0) begin
                        out_resp <= alu_resp_s;
                        out_data <= alu_data_s;
                        state_r  <= RESP;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        state_r <= EXEC;
                    end
                end
                // The response is held for exactly one cycle, then cleared.
                RESP: begin
                    out_resp <= RESP_NONE;
                    out_data <= 32'd0;
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    out_resp <= RESP_NONE;
                    out_data <= 32'd0;
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Self-checking bench for calc1_port_responder: directed protocol cases followed by
// randomized traffic, compared cycle by cycle against a transaction-level reference.
module tb_calc1_port_responder;

    localparam int LAT = 3;

    logic        c_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference transaction: the edge at which the command was taken, and its operands.
    bit          have_txn  = 1'b0;
    int          acc_edge  = 0;
    int          free_edge = 0;
    logic [3:0]  m_cmd;
    logic [31:0] m_op1;
    logic [31:0] m_op2;

    int          resp_seen = 0;
    logic [1:0]  last_resp = 2'd0;
    logic [31:0] last_data = 32'd0;

    calc1_port_responder #(.LATENCY(LAT)) dut (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 c_clk = ~c_clk;

    // Expected {resp, data} for a command, straight from the arithmetic rules.
    function automatic logic [33:0] ref_calc(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b);
        longint unsigned wide;
        case (cmd)
            4'd1: begin
                wide = 64'(a) + 64'(b);
                if (wide > 64'hFFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, wide[31:0]};
            end
            4'd2: begin
                if (b > a) return {2'd2, 32'd0};
                return {2'd1, a - b};
            end
            4'd5: return {2'd1, a << (b % 32)};
            4'd6: return {2'd1, a >> (b % 32)};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Drive one cycle, advance the reference on the edge, then compare all outputs.
    task automatic step(input logic rn, input logic [3:0] cmd, input logic [31:0] d);
        logic [33:0] e;
        logic        xb;
        int          k;
        reset_n     = rn;
        req_cmd_in  = cmd;
        req_data_in = d;
        @(posedge c_clk);
        edge_n++;
        k = edge_n;
        if (!rn) begin
            have_txn  = 1'b0;
            free_edge = k + 1;
        end else if (have_txn && k == acc_edge + 1) begin
            m_op2 = d;
        end else if (cmd != 4'd0 && k >= free_edge) begin
            have_txn  = 1'b1;
            acc_edge  = k;
            m_cmd     = cmd;
            m_op1     = d;
            free_edge = k + 3 + LAT;
        end
        xb = have_txn && (k < acc_edge + 2 + LAT);
        e  = (have_txn && k == acc_edge + 1 + LAT) ? ref_calc(m_cmd, m_op1, m_op2) : 34'd0;
        #1;
        check_eq("resp", 64'(out_resp), 64'(e[33:32]));
        check_eq("data", 64'(out_data), 64'(e[31:0]));
        check_eq("busy", 64'(busy), 64'(xb));
        if (out_resp != 2'd0) begin
            resp_seen++;
            last_resp = out_resp;
            last_data = out_data;
        end
    endtask

    // One request in the earliest possible slot; junk_cmd is presented while busy.
    task automatic dir(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] junk_cmd,
                       input logic [1:0] exp_resp, input logic [31:0] exp_data);
        int n0;
        n0 = resp_seen;
        step(1'b1, cmd, a);
        step(1'b1, junk_cmd, b);
        repeat (LAT + 1) step(1'b1, junk_cmd, $urandom);
        check_eq({tag, "_count"}, 64'(resp_seen - n0), 64'd1);
        check_eq(tag, 64'({last_resp, last_data}), 64'({exp_resp, exp_data}));
    endtask

    initial begin
        int n0;
        logic [3:0]  rc;
        logic [31:0] rd;
        step(1'b0, 4'd0, 32'd0);
        step(1'b0, 4'd0, 32'd0);
        step(1'b1, 4'd0, 32'd0);

        dir("add_1_5",      4'd1, 32'h1,        32'h5,        4'd0, 2'd1, 32'h6);
        dir("add_ovf",      4'd1, 32'hFFFFFFFF, 32'h1,        4'd0, 2'd2, 32'h0);
        dir("add_max",      4'd1, 32'hFFFFFFFE, 32'h1,        4'd0, 2'd1, 32'hFFFFFFFF);
        dir("sub_under",    4'd2, 32'h3,        32'h7,        4'd0, 2'd2, 32'h0);
        dir("sub_equal",    4'd2, 32'h7,        32'h7,        4'd0, 2'd1, 32'h0);
        dir("shl_wrap",     4'd5, 32'h1,        32'h21,       4'd0, 2'd1, 32'h2);
        dir("shr_msb",      4'd6, 32'h80000000, 32'h1F,       4'd0, 2'd1, 32'h1);
        dir("bad_cmd",      4'hF, 32'h12345678, 32'h9,        4'd0, 2'd2, 32'h0);
        dir("sub_busy",     4'd2, 32'h9,        32'h4,        4'd1, 2'd1, 32'h5);
        dir("add_back2bk",  4'd1, 32'h10,       32'h20,       4'd0, 2'd1, 32'h30);

        // Reset asserted while the request is executing.
        step(1'b1, 4'd1, 32'h7);
        step(1'b1, 4'd0, 32'h8);
        step(1'b1, 4'd0, 32'h0);
        step(1'b0, 4'd0, 32'h0);
        n0 = resp_seen;
        repeat (LAT + 4) step(1'b1, 4'd0, 32'h0);
        check_eq("rst_no_resp", 64'(resp_seen - n0), 64'd0);
        dir("add_after_rst", 4'd1, 32'h2, 32'h2, 4'd0, 2'd1, 32'h4);

        repeat (3000) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rc = 4'd0;
                4:          rc = 4'd1;
                5:          rc = 4'd2;
                6:          rc = 4'd5;
                7:          rc = 4'd6;
                default:    rc = 4'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       rd = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                1:       rd = 32'($urandom_range(0, 40));
                default: rd = $urandom;
            endcase
            step($urandom_range(0, 99) != 0, rc, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
